// File: rtl/excitation_generator.sv
// Excitation source for audio-rate test stimulus: single impulse, pulse train
// or LFSR-driven +/-amp noise, gated onto a per-channel mask and paced by step_in.
module excitation_generator #(
  parameter int WIDTH  = 16,
  parameter int CNT_W  = 16,
  parameter int NUM_CH = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    step_in,
  input  logic                    trigger_in,
  input  logic                    abort_in,
  input  logic [1:0]              mode_in,
  input  logic signed [WIDTH-1:0] amp_in,
  input  logic [CNT_W-1:0]        len_in,
  input  logic [CNT_W-1:0]        period_in,
  input  logic [7:0]              count_in,
  input  logic [NUM_CH-1:0]       ch_mask_in,
  output logic [NUM_CH*WIDTH-1:0] amp_out,
  output logic                    busy_out,
  output logic                    done_out
);

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, GAP} state_e;
  typedef enum logic [1:0] {MODE_IMPULSE, MODE_TRAIN, MODE_NOISE, MODE_RSVD} mode_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic signed [WIDTH-1:0] AMP_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] AMP_MAX = {1'b0, {(WIDTH-1){1'b1}}};

  state_e                    state_q, state_d;
  mode_e                     mode_q, mode_d;
  logic signed [WIDTH-1:0]   amp_q, amp_d;
  logic [CNT_W-1:0]          len_q, len_d;
  logic [CNT_W-1:0]          gap_q, gap_d;
  logic [7:0]                count_q, count_d;
  logic [NUM_CH-1:0]         mask_q, mask_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]          gcnt_q, gcnt_d;
  logic [7:0]                pulse_q, pulse_d;
  logic [15:0]               lfsr_q, lfsr_d;
  logic [NUM_CH*WIDTH-1:0]   out_q, out_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic [CNT_W-1:0]          len_eff;
  logic signed [WIDTH-1:0]   amp_neg;
  logic signed [WIDTH-1:0]   sample;
  logic [NUM_CH*WIDTH-1:0]   sample_vec;
  logic [15:0]               lfsr_adv;
  logic                      emit;

  assign len_eff  = (len_in == '0) ? CNT_W'(1) : len_in;
  assign amp_neg  = (amp_q == AMP_MIN) ? AMP_MAX : -amp_q;
  assign sample   = (mode_q == MODE_NOISE && !lfsr_q[0]) ? amp_neg : amp_q;
  assign lfsr_adv = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

  always_comb begin
    sample_vec = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      sample_vec[c*WIDTH +: WIDTH] = mask_q[c] ? sample : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    amp_d   = amp_q;
    len_d   = len_q;
    gap_d   = gap_q;
    count_d = count_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    pulse_d = pulse_q;
    lfsr_d  = lfsr_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    emit    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (trigger_in && !abort_in) begin
          state_d = ARMED;
          mode_d  = mode_e'(mode_in);
          amp_d   = amp_in;
          len_d   = len_eff;
          // Gap is P - len with P = max(period, len+1); never below one zero step.
          gap_d   = (period_in > len_eff) ? (period_in - len_eff) : CNT_W'(1);
          count_d = (count_in == 8'd0) ? 8'd1 : count_in;
          mask_d  = ch_mask_in;
          cnt_d   = '0;
          gcnt_d  = '0;
          pulse_d = '0;
          lfsr_d  = LFSR_SEED;
          busy_d  = 1'b1;
        end
      end
      ARMED: begin
        if (step_in) begin
          emit    = 1'b1;
          cnt_d   = CNT_W'(1);
          pulse_d = 8'd1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (step_in) begin
          if (cnt_q < len_q) begin
            emit  = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            out_d = '0;
            cnt_d = '0;
            if (mode_q == MODE_TRAIN && pulse_q < count_q) begin
              gcnt_d  = CNT_W'(1);
              state_d = GAP;
            end else begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end
      end
      GAP: begin
        if (step_in) begin
          if (gcnt_q < gap_q) begin
            gcnt_d = gcnt_q + CNT_W'(1);
            out_d  = '0;
          end else begin
            emit    = 1'b1;
            gcnt_d  = '0;
            cnt_d   = CNT_W'(1);
            pulse_d = pulse_q + 8'd1;
            state_d = ACTIVE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort_in && state_q != IDLE) begin
      state_d = IDLE;
      out_d   = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else if (emit) begin
      out_d = sample_vec;
      if (mode_q == MODE_NOISE) lfsr_d = lfsr_adv;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      mode_q  <= MODE_IMPULSE;
      amp_q   <= '0;
      len_q   <= '0;
      gap_q   <= '0;
      count_q <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      pulse_q <= '0;
      lfsr_q  <= LFSR_SEED;
      out_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      amp_q   <= amp_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      count_q <= count_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      pulse_q <= pulse_d;
      lfsr_q  <= lfsr_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign amp_out  = out_q;
  assign busy_out = busy_q;
  assign done_out = done_q;

endmodule

// File: tb/tb_excitation_generator.sv
// Directed bench for excitation_generator: a vector table for the impulse run
// plus hand sequences for train, noise, abort, degenerate config and reset.
module tb_excitation_generator;

  logic               clk = 1'b0;
  logic               rst;
  logic               step, trigger, abort;
  logic [1:0]         mode;
  logic signed [15:0] amp;
  logic [15:0]        len, period;
  logic [7:0]         count;
  logic [1:0]         mask;
  logic [31:0]        amp_o;
  logic               busy, done;

  int n_checks = 0;
  int n_errors = 0;

  excitation_generator #(.WIDTH(16), .CNT_W(16), .NUM_CH(2)) dut (
    .clk_in(clk), .rst_in(rst), .step_in(step), .trigger_in(trigger),
    .abort_in(abort), .mode_in(mode), .amp_in(amp), .len_in(len),
    .period_in(period), .count_in(count), .ch_mask_in(mask),
    .amp_out(amp_o), .busy_out(busy), .done_out(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stp, trg, abt;
    logic [31:0] exp_amp;
    logic        exp_busy, exp_done;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cfg(input logic [1:0] m, input logic [15:0] a, input logic [15:0] l,
                     input logic [15:0] p, input logic [7:0] c, input logic [1:0] mk);
    mode = m; amp = a; len = l; period = p; count = c; mask = mk;
  endtask

  // Drive inputs for one cycle, then check outputs just after the rising edge.
  task automatic tick(input string nm, input logic stp, input logic trg, input logic abt,
                      input logic [31:0] e_amp, input logic e_busy, input logic e_done);
    @(negedge clk);
    step = stp; trigger = trg; abort = abt;
    @(posedge clk);
    #1;
    chk({nm, ".amp"},  amp_o, e_amp);
    chk({nm, ".busy"}, {31'd0, busy}, {31'd0, e_busy});
    chk({nm, ".done"}, {31'd0, done}, {31'd0, e_done});
  endtask

  vec_t vt[13];
  logic [15:0] train_pat[13];
  logic [15:0] noise_pat[4];

  initial begin
    vt[0]  = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0}; // trigger -> ARMED
    vt[1]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0}; // no sample before step
    vt[2]  = '{1'b1, 1'b0, 1'b0, 32'h0000_DFFF, 1'b1, 1'b0}; // step 1
    vt[3]  = '{1'b0, 1'b0, 1'b0, 32'h0000_DFFF, 1'b1, 1'b0}; // hold between steps
    vt[4]  = '{1'b1, 1'b0, 1'b0, 32'h0000_DFFF, 1'b1, 1'b0}; // step 2
    vt[5]  = '{1'b0, 1'b1, 1'b0, 32'h0000_DFFF, 1'b1, 1'b0}; // trigger ignored
    vt[6]  = '{1'b1, 1'b0, 1'b0, 32'h0000_DFFF, 1'b1, 1'b0}; // step 3
    vt[7]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1}; // step 4 -> done
    vt[8]  = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0}; // done is one cycle
    vt[9]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0}; // step 5 in IDLE
    vt[10] = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b0}; // abort beats trigger
    vt[11] = '{1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
    vt[12] = '{1'b1, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0}; // still IDLE

    train_pat = '{16'd1000, 16'd1000, 16'd0, 16'd0, 16'd0,
                  16'd1000, 16'd1000, 16'd0, 16'd0, 16'd0,
                  16'd1000, 16'd1000, 16'd0};
    // ACE1 LFSR bit0 sequence 1,0,0,0 with amp = most-negative value.
    noise_pat = '{16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF};

    rst = 1'b1; step = 1'b0; trigger = 1'b0; abort = 1'b0;
    cfg(2'd0, 16'h0000, 16'd0, 16'd0, 8'd0, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.amp",  amp_o, 32'h0);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // IMPULSE amp=DFFF len=3 mask=01
    cfg(2'd0, 16'hDFFF, 16'd3, 16'd0, 8'd1, 2'b01);
    for (int i = 0; i < 13; i++) begin
      tick($sformatf("imp[%0d]", i), vt[i].stp, vt[i].trg, vt[i].abt,
           vt[i].exp_amp, vt[i].exp_busy, vt[i].exp_done);
    end

    // Mode 3 behaves as IMPULSE, both channels masked
    cfg(2'd3, 16'd5, 16'd1, 16'd0, 8'd1, 2'b11);
    tick("m3.trig", 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    tick("m3.s1",   1'b1, 1'b0, 1'b0, 32'h0005_0005, 1'b1, 1'b0);
    tick("m3.s2",   1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // TRAIN amp=1000 len=2 period=5 count=3
    cfg(2'd1, 16'd1000, 16'd2, 16'd5, 8'd3, 2'b11);
    tick("tr.trig", 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) begin
      tick($sformatf("tr.s%0d", i + 1), 1'b1, 1'b0, 1'b0,
           {train_pat[i], train_pat[i]}, (i != 12), (i == 12));
    end
    tick("tr.after", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // NOISE amp=-32768 len=4 on ch1, twice to show the reseed
    cfg(2'd2, 16'h8000, 16'd4, 16'd0, 8'd1, 2'b10);
    for (int r = 0; r < 2; r++) begin
      tick($sformatf("nz%0d.trig", r), 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
        tick($sformatf("nz%0d.s%0d", r, i + 1), 1'b1, 1'b0, 1'b0,
             {noise_pat[i], 16'h0000}, 1'b1, 1'b0);
      end
      tick($sformatf("nz%0d.end", r), 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      tick($sformatf("nz%0d.gap", r), 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    end

    // Abort after two active steps; mid-run trigger with new amp is ignored
    cfg(2'd0, 16'd7, 16'd5, 16'd0, 8'd1, 2'b01);
    tick("ab.trig", 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    tick("ab.s1",   1'b1, 1'b0, 1'b0, 32'h0000_0007, 1'b1, 1'b0);
    amp = 16'd99;
    tick("ab.retrig", 1'b0, 1'b1, 1'b0, 32'h0000_0007, 1'b1, 1'b0);
    tick("ab.s2",   1'b1, 1'b0, 1'b0, 32'h0000_0007, 1'b1, 1'b0);
    tick("ab.abort", 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    tick("ab.post", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Abort coincident with the completing step: no done
    cfg(2'd0, 16'd7, 16'd1, 16'd0, 8'd1, 2'b01);
    tick("abd.trig", 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    tick("abd.s1",   1'b1, 1'b0, 1'b0, 32'h0000_0007, 1'b1, 1'b0);
    tick("abd.both", 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    tick("abd.post", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // TRAIN with len=0 count=0 period=0 -> one 1-step pulse
    cfg(2'd1, 16'd200, 16'd0, 16'd0, 8'd0, 2'b01);
    tick("z.trig", 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    tick("z.s1",   1'b1, 1'b0, 1'b0, 32'h0000_00C8, 1'b1, 1'b0);
    tick("z.s2",   1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick("z.s3",   1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Reset mid-ACTIVE clears outputs without waiting for a clock edge
    cfg(2'd0, 16'h1234, 16'd5, 16'd0, 8'd1, 2'b11);
    tick("rs.trig", 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    tick("rs.s1",   1'b1, 1'b0, 1'b0, 32'h1234_1234, 1'b1, 1'b0);
    step = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rs.async.amp",  amp_o, 32'h0);
    chk("rs.async.busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick($sformatf("rs.post%0d", i), 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/excitation_generator.md
EXCITATION_GENERATOR -- requirements
Module: excitation_generator

Interface
REQ-001 SHALL have parameter WIDTH, default 16: sample width, signed two's complement.
REQ-002 SHALL have parameter CNT_W, default 16: width of length/period counters.
REQ-003 SHALL have parameter NUM_CH, default 2: number of output channels.
REQ-004 clk_in  in  1  sole clock; all logic on rising edge.
REQ-005 rst_in  in  1  reset, asynchronous, active-high.
REQ-006 step_in  in  1  audio-rate strobe, one cycle wide.
REQ-007 trigger_in  in  1  start request, sampled every cycle.
REQ-008 abort_in  in  1  cancel request, sampled every cycle.
REQ-009 mode_in  in  2  0=IMPULSE, 1=TRAIN, 2=NOISE, 3=reserved.
REQ-010 amp_in  in  WIDTH  signed excitation amplitude.
REQ-011 len_in  in  CNT_W  active length in steps; 0 treated as 1.
REQ-012 period_in  in  CNT_W  TRAIN start-to-start spacing in steps.
REQ-013 count_in  in  8  TRAIN pulse count; 0 treated as 1.
REQ-014 ch_mask_in  in  NUM_CH  channels receiving the excitation.
REQ-015 amp_out  out  NUM_CH*WIDTH  channel c in bits [c*WIDTH +: WIDTH].
REQ-016 busy_out  out  1  high from the cycle after accepted trigger until return to IDLE.
REQ-017 done_out  out  1  one-cycle pulse on normal completion.

Function
REQ-018 States SHALL be IDLE, ARMED, ACTIVE, GAP; all outputs registered.
REQ-019 In IDLE, trigger_in without abort_in SHALL latch mode, amp, len, period, count, mask and go to ARMED next cycle.
REQ-020 trigger_in SHALL be ignored in every state other than IDLE; latched config SHALL not change mid-run.
REQ-021 Mode 3 SHALL behave as IMPULSE.
REQ-022 ARMED SHALL wait for step_in; on it, go ACTIVE and drive first sample; no sample before the first step_in.
REQ-023 amp_out SHALL change only on step_in cycles, reset, or abort.
REQ-024 ACTIVE SHALL last exactly len steps (len=0 -> 1); each step_in drives the current sample to masked channels, zero to unmasked.
REQ-025 IMPULSE: sample = amp for len steps, then zero.
REQ-026 NOISE: sample = +amp if LFSR bit0=1 else -amp; -amp of most-negative value SHALL saturate to max positive.
REQ-027 LFSR SHALL be 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, seeded 16'hACE1 on reset and on each accepted trigger, advanced once per ACTIVE step_in after sampling.
REQ-028 TRAIN: count pulses of len steps at amp, separated by GAP of (P - len) zero steps, P = max(period, len+1).
REQ-029 On the step_in that ends the final active step, amp_out SHALL go zero, done_out SHALL pulse that cycle, busy_out SHALL drop, state SHALL return to IDLE.
REQ-030 A new trigger SHALL be accepted in the cycle after done_out.
REQ-031 abort_in in any non-IDLE state SHALL zero amp_out, clear busy_out, go IDLE next cycle, with no done_out.
REQ-032 abort_in and trigger_in together in IDLE: abort wins, no start.
REQ-033 abort_in and completing step_in together: abort wins, no done_out.

Reset
REQ-034 rst_in SHALL asynchronously force IDLE, amp_out=0, busy_out=0, done_out=0, LFSR=16'hACE1, counters=0.
REQ-035 Reset mid-run SHALL discard the run; no done_out after release.

Verification
REQ-036 IMPULSE, amp=16'shDFFF, len=3, mask=2'b01: trigger, 5 step_in -> ch0=DFFF for steps 1-3, zero at step 4 with done_out; ch1 always 0.
REQ-037 TRAIN, amp=1000, len=2, period=5, count=3: -> pattern 1000,1000,0,0,0 x2 then 1000,1000,0; one done_out at final zero step.
REQ-038 NOISE, amp=-32768, len=4: -> outputs match reference LFSR from ACE1; -amp values = 32767; identical sequence on retrigger.
REQ-039 Abort after 2 ACTIVE steps -> amp_out=0, busy_out=0 next cycle, no done_out; second trigger during run ignored.
REQ-040 len=0, count=0, period=0 TRAIN -> single 1-step pulse, done next step; rst_in asserted mid-ACTIVE -> immediate zero outputs.
